// File: rtl/nanorv32_urom_seq_if.sv
// Handshake bundle between the micro-ROM sequencer (master) and the
// interrupt controller / core instruction path (slave).
interface nanorv32_urom_seq_if #(
  parameter int UROM_ADDR_W = 5
);
  logic                   irq_req;
  logic                   irq_safe;
  logic                   irq_ret;
  logic                   instr_ready;
  logic [UROM_ADDR_W-1:0] urom_addr;
  logic                   urom_sel;
  logic                   urom_valid;
  logic                   irq_ack;
  logic                   in_irq;
  logic                   seq_done;
  logic                   seq_err;

  modport master (
    input  irq_req, irq_safe, irq_ret, instr_ready,
    output urom_addr, urom_sel, urom_valid, irq_ack, in_irq, seq_done, seq_err
  );

  modport slave (
    output irq_req, irq_safe, irq_ret, instr_ready,
    input  urom_addr, urom_sel, urom_valid, irq_ack, in_irq, seq_done, seq_err
  );
endinterface

// File: rtl/nanorv32_urom_seq.sv
// nanorv32 micro-ROM sequencer: reset, interrupt-entry and interrupt-exit sequences.
// Optional stall watchdog enabled by defining NANORV32_UROM_SEQ_STALL_CHECK_EN.
module nanorv32_urom_seq #(
  parameter int UROM_ADDR_W   = 5,
  parameter int RESET_START   = 0,
  parameter int RESET_LEN     = 2,
  parameter int ENTRY_START   = 2,
  parameter int ENTRY_LEN     = 16,
  parameter int EXIT_START    = 18,
  parameter int EXIT_LEN      = 2,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nanorv32_urom_seq_if.master   bus
);

  if (RESET_LEN < 1 || ENTRY_LEN < 1 || EXIT_LEN < 1 || STALL_TIMEOUT < 1) begin : g_bad_cfg
    $error("nanorv32_urom_seq: sequence lengths and STALL_TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    RST_SEQ,
    RUN,
    ENTRY,
    HANDLER,
    EXIT
  } state_t;

  localparam logic [UROM_ADDR_W-1:0] RESET_ADDR = UROM_ADDR_W'(RESET_START);
  localparam logic [UROM_ADDR_W-1:0] ENTRY_ADDR = UROM_ADDR_W'(ENTRY_START);
  localparam logic [UROM_ADDR_W-1:0] EXIT_ADDR  = UROM_ADDR_W'(EXIT_START);
  localparam logic [UROM_ADDR_W-1:0] RESET_CNT  = UROM_ADDR_W'(RESET_LEN - 1);
  localparam logic [UROM_ADDR_W-1:0] ENTRY_CNT  = UROM_ADDR_W'(ENTRY_LEN - 1);
  localparam logic [UROM_ADDR_W-1:0] EXIT_CNT   = UROM_ADDR_W'(EXIT_LEN - 1);

  state_t                 r_state, w_state_nxt;
  logic [UROM_ADDR_W-1:0] r_addr,  w_addr_nxt;
  logic [UROM_ADDR_W-1:0] r_cnt,   w_cnt_nxt;
  logic                   r_irq_ack, w_irq_ack_nxt;
  logic                   r_in_irq,  w_in_irq_nxt;

  logic w_valid;
  logic w_accept;
  logic w_last;

  assign w_valid  = (r_state == RST_SEQ) || (r_state == ENTRY) || (r_state == EXIT);
  assign w_accept = w_valid && bus.instr_ready;
  assign w_last   = w_accept && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RST_SEQ;
      r_addr    <= RESET_ADDR;
      r_cnt     <= RESET_CNT;
      r_irq_ack <= 1'b0;
      r_in_irq  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_irq_ack <= w_irq_ack_nxt;
      r_in_irq  <= w_in_irq_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_cnt_nxt     = r_cnt;
    w_irq_ack_nxt = 1'b0;
    w_in_irq_nxt  = r_in_irq;

    unique case (r_state)
      RST_SEQ, ENTRY, EXIT: begin
        if (w_last) begin
          // The address is left on the last word; it is only meaningful while valid.
          unique case (r_state)
            ENTRY: begin
              w_state_nxt  = HANDLER;
              w_in_irq_nxt = 1'b1;
            end
            EXIT: begin
              w_state_nxt  = RUN;
              w_in_irq_nxt = 1'b0;
            end
            default: w_state_nxt = RUN;
          endcase
        end else if (w_accept) begin
          w_addr_nxt = r_addr + 1'b1;
          w_cnt_nxt  = r_cnt - 1'b1;
        end
      end
      RUN: begin
        if (bus.irq_req && bus.irq_safe) begin
          w_state_nxt   = ENTRY;
          w_addr_nxt    = ENTRY_ADDR;
          w_cnt_nxt     = ENTRY_CNT;
          w_irq_ack_nxt = 1'b1;
        end
      end
      HANDLER: begin
        if (bus.irq_ret) begin
          w_state_nxt = EXIT;
          w_addr_nxt  = EXIT_ADDR;
          w_cnt_nxt   = EXIT_CNT;
        end
      end
      default: w_state_nxt = RST_SEQ;
    endcase
  end

  assign bus.urom_addr  = r_addr;
  assign bus.urom_sel   = w_valid;
  assign bus.urom_valid = w_valid;
  assign bus.irq_ack    = r_irq_ack;
  assign bus.in_irq     = r_in_irq;
  assign bus.seq_done   = w_last;

`ifdef NANORV32_UROM_SEQ_STALL_CHECK_EN
  localparam int unsigned             STALL_W   = $clog2(STALL_TIMEOUT + 1);
  localparam logic [STALL_W-1:0]      STALL_MAX = STALL_W'(STALL_TIMEOUT);
  localparam logic [STALL_W-1:0]      STALL_PRE = STALL_W'(STALL_TIMEOUT - 1);

  logic [STALL_W-1:0] r_stall;
  logic               r_seq_err;
  logic               w_stalled;

  assign w_stalled = w_valid && !bus.instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall   <= '0;
      r_seq_err <= 1'b0;
    end else begin
      if (!w_stalled) begin
        r_stall <= '0;
      end else if (r_stall != STALL_MAX) begin
        r_stall <= r_stall + 1'b1;
      end
      // Flag on the edge that completes the STALL_TIMEOUT-th stalled cycle.
      if (w_stalled && (r_stall >= STALL_PRE)) begin
        r_seq_err <= 1'b1;
      end
    end
  end

  assign bus.seq_err = r_seq_err;
`else
  assign bus.seq_err = 1'b0;
`endif

endmodule
